// File: rtl/pio_input_edge_capture_if.sv
// pio_input_edge_capture_if: Avalon-MM slave bus bundle for the PIO input port
//   address    - word address of the register
//   chipselect - slave select
//   write_n    - active-low write strobe, qualified by chipselect
//   writedata  - write data
//   readdata   - combinational read data, zero-extended above the port width
//   irq        - active-high level interrupt
interface pio_input_edge_capture_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/pio_input_edge_capture.sv
// pio_input_edge_capture: Avalon-MM PIO input port with synchronizer, sticky edge capture and irq
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   i_in_port - asynchronous external inputs
//   bus       - Avalon-MM slave: 0 data (RO), 1 reserved, 2 irq_mask (RW), 3 edge_capture (W1C)
module pio_input_edge_capture #(
   parameter int WIDTH     = 18,
   parameter int EDGE_TYPE = 0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [WIDTH-1:0]              i_in_port,
   pio_input_edge_capture_if.slave       bus
);
   logic [WIDTH-1:0] r_sync_a, r_sync_b, r_prev, r_irq_mask, r_edge_capture;
   logic [1:0]       r_prime;
   logic [WIDTH-1:0] w_raw, w_edge, w_clr;
   logic             w_wr, w_unused;
   assign w_wr  = bus.chipselect & ~bus.write_n;
   assign w_raw = (EDGE_TYPE == 0) ? (r_sync_b & ~r_prev) :
                  (EDGE_TYPE == 1) ? (~r_sync_b & r_prev) : (r_sync_b ^ r_prev);
   // Edges are suppressed until the synchronizer pipeline holds real samples,
   // so inputs already high at reset release never look like a rising edge.
   assign w_edge = (r_prime == 2'd3) ? w_raw : '0;
   assign w_clr  = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
   assign w_unused = ^bus.writedata;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync_a       <= '0;
         r_sync_b       <= '0;
         r_prev         <= '0;
         r_irq_mask     <= '0;
         r_edge_capture <= '0;
         r_prime        <= '0;
      end else begin
         r_sync_a       <= i_in_port;
         r_sync_b       <= r_sync_a;
         r_prev         <= r_sync_b;
         r_prime        <= (r_prime == 2'd3) ? r_prime : r_prime + 2'd1;
         r_irq_mask     <= (w_wr && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : r_irq_mask;
         // A fresh edge beats a simultaneous clear of the same bit.
         r_edge_capture <= (r_edge_capture & ~w_clr) | w_edge;
      end
   end
   assign bus.readdata = (bus.address == 2'd0) ? 32'(r_sync_b) :
                         (bus.address == 2'd2) ? 32'(r_irq_mask) :
                         (bus.address == 2'd3) ? 32'(r_edge_capture) : 32'd0;
   assign bus.irq = |(r_edge_capture & r_irq_mask);
endmodule

// File: tb/tb_pio_input_edge_capture.sv
// tb_pio_input_edge_capture: directed bench with a history-based reference model for both edge types
module tb_pio_input_edge_capture;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [17:0] in0, in2;
   int          checks = 0;
   int          errors = 0;

   pio_input_edge_capture_if b0 ();
   pio_input_edge_capture_if b2 ();

   pio_input_edge_capture #(.WIDTH(18), .EDGE_TYPE(0)) u0 (
      .clk(clk), .reset_n(reset_n), .i_in_port(in0), .bus(b0));
   pio_input_edge_capture #(.WIDTH(18), .EDGE_TYPE(2)) u2 (
      .clk(clk), .reset_n(reset_n), .i_in_port(in2), .bus(b2));

   always #5 clk = ~clk;

   // Model: h*[k] is the input value seen at the k-th edge after reset release.
   // Data register after edge n shows h[n-1]; edge n captures the transition
   // h[n-3] -> h[n-2], but only from the 4th edge on.
   int          n;
   logic [17:0] h0 [8];
   logic [17:0] h2 [8];
   logic [17:0] cap0, mask0, cap2, mask2, e0, e2, clr0, clr2;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         n = 0;
         cap0 = '0; mask0 = '0; cap2 = '0; mask2 = '0;
      end else begin
         n = n + 1;
         h0[n % 8] = in0;
         h2[n % 8] = in2;
         e0 = (n >= 4) ? (h0[(n-2) % 8] & ~h0[(n-3) % 8]) : '0;
         e2 = (n >= 4) ? (h2[(n-2) % 8] ^ h2[(n-3) % 8]) : '0;
         clr0 = (b0.chipselect && !b0.write_n && b0.address == 2'd3) ? b0.writedata[17:0] : '0;
         clr2 = (b2.chipselect && !b2.write_n && b2.address == 2'd3) ? b2.writedata[17:0] : '0;
         if (b0.chipselect && !b0.write_n && b0.address == 2'd2) mask0 = b0.writedata[17:0];
         if (b2.chipselect && !b2.write_n && b2.address == 2'd2) mask2 = b2.writedata[17:0];
         cap0 = (cap0 & ~clr0) | e0;
         cap2 = (cap2 & ~clr2) | e2;
      end
   end

   function automatic logic [31:0] exp_rd(logic [1:0] a, logic [17:0] d, logic [17:0] m, logic [17:0] c);
      return (a == 2'd0) ? 32'(d) : (a == 2'd2) ? 32'(m) : (a == 2'd3) ? 32'(c) : 32'd0;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [17:0] sb0, sb2;
      #1;
      sb0 = (reset_n && n >= 2) ? h0[(n-1) % 8] : '0;
      sb2 = (reset_n && n >= 2) ? h2[(n-1) % 8] : '0;
      chk("cyc_rd0", b0.readdata, exp_rd(b0.address, sb0, mask0, cap0));
      chk("cyc_irq0", 32'(b0.irq), 32'(|(cap0 & mask0)));
      chk("cyc_rd2", b2.readdata, exp_rd(b2.address, sb2, mask2, cap2));
      chk("cyc_irq2", 32'(b2.irq), 32'(|(cap2 & mask2)));
   end

   task automatic setbus(int s, logic [1:0] a, logic cs, logic wn, logic [31:0] wd);
      if (s == 0) begin
         b0.address = a; b0.chipselect = cs; b0.write_n = wn; b0.writedata = wd;
      end else begin
         b2.address = a; b2.chipselect = cs; b2.write_n = wn; b2.writedata = wd;
      end
   endtask

   task automatic rd(int s, logic [1:0] a, logic [31:0] req, string nm);
      @(negedge clk);
      setbus(s, a, 1'b1, 1'b1, 32'd0);
      #2;
      chk(nm, (s == 0) ? b0.readdata : b2.readdata, req);
   endtask

   task automatic wr(int s, logic [1:0] a, logic [31:0] wd);
      @(negedge clk);
      setbus(s, a, 1'b1, 1'b0, wd);
      @(negedge clk);
      setbus(s, a, 1'b0, 1'b1, 32'd0);
   endtask

   task automatic cyc(int k);
      repeat (k) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      setbus(0, 2'd0, 1'b0, 1'b1, 32'd0);
      setbus(2, 2'd0, 1'b0, 1'b1, 32'd0);
      in0 = 18'h3FFFF;
      in2 = 18'h3FFFF;
      cyc(3);
      reset_n = 1'b1;
      // 1: inputs high through reset, no false edge
      @(posedge clk);
      @(posedge clk);
      rd(0, 2'd0, 32'h0003FFFF, "t1_data0");
      rd(2, 2'd0, 32'h0003FFFF, "t1_data2");
      rd(0, 2'd3, 32'd0, "t1_cap0");
      rd(2, 2'd3, 32'd0, "t1_cap2");
      chk("t1_irq0", 32'(b0.irq), 32'd0);
      cyc(8);
      // 2: rising-edge capture, then unmask
      @(negedge clk); in0 = 18'h0;
      cyc(4);
      rd(0, 2'd3, 32'd0, "t2_fall_ignored");
      @(negedge clk); in0 = 18'h20;
      rd(0, 2'd3, 32'd0, "t2_lat1");
      rd(0, 2'd3, 32'd0, "t2_lat2");
      rd(0, 2'd3, 32'h20, "t2_cap");
      chk("t2_irq_masked", 32'(b0.irq), 32'd0);
      wr(0, 2'd2, 32'h20);
      chk("t2_irq_on", 32'(b0.irq), 32'd1);
      // 3: write-1-to-clear
      @(negedge clk); in0 = 18'h21;
      cyc(2);
      rd(0, 2'd3, 32'h21, "t3_cap21");
      wr(0, 2'd3, 32'h01);
      rd(0, 2'd3, 32'h20, "t3_cap20");
      chk("t3_irq_still", 32'(b0.irq), 32'd1);
      wr(0, 2'd3, 32'h20);
      rd(0, 2'd3, 32'd0, "t3_cap0");
      chk("t3_irq_off", 32'(b0.irq), 32'd0);
      // 4: clear lands on the same edge as a new bit-0 edge
      @(negedge clk); in0 = 18'h20;
      cyc(4);
      @(negedge clk); in0 = 18'h21;
      @(negedge clk);
      wr(0, 2'd3, 32'h01);
      rd(0, 2'd3, 32'h01, "t4_collide");
      wr(0, 2'd3, 32'h01);
      rd(0, 2'd3, 32'd0, "t4_later_clear");
      // 5: any-edge instance on the top bit
      @(negedge clk); in2 = 18'h0;
      cyc(4);
      wr(2, 2'd3, 32'h3FFFF);
      rd(2, 2'd3, 32'd0, "t5_cleared");
      @(negedge clk); in2 = 18'h20000;
      rd(2, 2'd3, 32'd0, "t5_r_lat1");
      rd(2, 2'd3, 32'd0, "t5_r_lat2");
      rd(2, 2'd3, 32'h20000, "t5_rise");
      wr(2, 2'd3, 32'h20000);
      rd(2, 2'd3, 32'd0, "t5_clr");
      @(negedge clk); in2 = 18'h0;
      rd(2, 2'd3, 32'd0, "t5_f_lat1");
      rd(2, 2'd3, 32'd0, "t5_f_lat2");
      rd(2, 2'd3, 32'h20000, "t5_fall");
      wr(2, 2'd2, 32'hFFFFFFFF);
      rd(2, 2'd2, 32'h0003FFFF, "t5_mask_zext");
      chk("t5_irq2", 32'(b2.irq), 32'd1);
      rd(2, 2'd1, 32'd0, "t5_reserved");
      wr(2, 2'd3, 32'hFFFFFFFF);
      rd(2, 2'd3, 32'd0, "t5_clr_all");
      // 6: asynchronous reset mid-operation
      @(negedge clk); in0 = 18'h0;
      cyc(4);
      wr(0, 2'd3, 32'h3FFFF);
      wr(0, 2'd2, 32'h3);
      @(negedge clk); in0 = 18'h3;
      rd(0, 2'd3, 32'd0, "t6_lat1");
      rd(0, 2'd3, 32'd0, "t6_lat2");
      rd(0, 2'd3, 32'h3, "t6_cap3");
      chk("t6_irq_pre", 32'(b0.irq), 32'd1);
      @(negedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("t6_irq_async", 32'(b0.irq), 32'd0);
      chk("t6_cap_async", b0.readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      setbus(0, 2'd0, 1'b1, 1'b1, 32'd0);
      #1 chk("t6_data_rel", b0.readdata, 32'd0);
      setbus(0, 2'd2, 1'b1, 1'b1, 32'd0);
      #1 chk("t6_mask_rel", b0.readdata, 32'd0);
      setbus(0, 2'd3, 1'b1, 1'b1, 32'd0);
      #1 chk("t6_cap_rel", b0.readdata, 32'd0);
      chk("t6_irq_rel", 32'(b0.irq), 32'd0);
      cyc(10);
      rd(0, 2'd3, 32'd0, "t6_no_false_edge");
      rd(0, 2'd0, 32'h3, "t6_data");
      cyc(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
